// File: rtl/bram_frame_writer.sv
`default_nettype none
// ============================================================================
//  Module      : bram_frame_writer
//  Description : Writer side of the image frame buffer. Takes a raster-ordered
//                pixel stream (valid/ready with SOF/EOL side-band) and stores
//                one complete frame into BRAM port A at linear addresses
//                0 .. IMG_W*IMG_H-1. The reader drains port B in its own
//                clock domain.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    IMG_W, IMG_H : frame geometry in pixels / lines
//    DATA_W       : pixel width (= BRAM port A data width)
//    ADDR_W       : BRAM port A address width, IMG_W*IMG_H <= 2**ADDR_W
//  Ports
//    clka        in   write clock (BRAM port A clock)
//    RESET_N     in   asynchronous active-low reset
//    start       in   pulse, arms capture of the next frame
//    abort       in   pulse, cancels the capture in progress
//    s_valid     in   pixel valid
//    s_ready     out  writer can accept a pixel
//    s_sof       in   first pixel of frame (qualified by s_valid)
//    s_eol       in   last pixel of line   (qualified by s_valid)
//    s_data      in   pixel value
//    ena/wea     out  BRAM port A enable / write enable
//    addra/dina  out  BRAM port A address / write data
//    busy        out  capture armed or in progress
//    frame_done  out  pulse with the write of the last pixel
//    sof_err     out  pulse when SOF arrives mid-frame (frame resyncs)
//    eol_err     out  pulse when s_eol disagrees with the column position
// ============================================================================
module bram_frame_writer #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 12
) (
    input  logic              clka,
    input  logic              RESET_N,
    input  logic              start,
    input  logic              abort,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              s_sof,
    input  logic              s_eol,
    input  logic [DATA_W-1:0] s_data,
    output logic              ena,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    output logic              busy,
    output logic              frame_done,
    output logic              sof_err,
    output logic              eol_err
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [CW-1:0] C_COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] C_ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t            state_q;
    logic [CW-1:0]     col_q;
    logic [RW-1:0]     row_q;
    logic [ADDR_W-1:0] lin_q;
    logic              ena_q;
    logic              wea_q;
    logic [ADDR_W-1:0] addra_q;
    logic [DATA_W-1:0] dina_q;
    logic              busy_q;
    logic              frame_done_q;
    logic              sof_err_q;
    logic              eol_err_q;

    logic              w_accept;
    logic              w_take;
    logic [CW-1:0]     w_col;
    logic [RW-1:0]     w_row;
    logic [ADDR_W-1:0] w_lin;
    logic              w_col_wrap;
    logic              w_last;
    logic [CW-1:0]     col_d;
    logic [RW-1:0]     row_d;
    logic [ADDR_W-1:0] lin_d;

    always_comb begin
        // abort blocks acceptance in the same cycle, so nothing slips in
        // while the capture is being cancelled.
        s_ready  = (state_q != ST_IDLE) && !abort;
        w_accept = s_valid && s_ready;
        // In ARM only an SOF beat is stored; earlier beats are discarded.
        w_take   = w_accept && (s_sof || (state_q == ST_WRITE));

        // An SOF beat always lands at the frame origin, whether it starts
        // the frame or resynchronises one already in flight.
        w_col = s_sof ? '0 : col_q;
        w_row = s_sof ? '0 : row_q;
        w_lin = s_sof ? '0 : lin_q;

        w_col_wrap = (w_col == C_COL_LAST);
        w_last     = w_col_wrap && (w_row == C_ROW_LAST);

        col_d = w_col_wrap ? '0 : (w_col + CW'(1));
        row_d = w_row;
        if (w_col_wrap) begin
            row_d = (w_row == C_ROW_LAST) ? '0 : (w_row + RW'(1));
        end
        // Linear address counter avoids a row*IMG_W multiplier.
        lin_d = w_last ? '0 : (w_lin + ADDR_W'(1));
    end

    always_ff @(posedge clka or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= ST_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            lin_q        <= '0;
            ena_q        <= 1'b0;
            wea_q        <= 1'b0;
            addra_q      <= '0;
            dina_q       <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            sof_err_q    <= 1'b0;
            eol_err_q    <= 1'b0;
        end else begin
            ena_q        <= 1'b0;
            wea_q        <= 1'b0;
            frame_done_q <= 1'b0;
            sof_err_q    <= 1'b0;
            eol_err_q    <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        state_q <= ST_ARM;
                        busy_q  <= 1'b1;
                    end
                end

                ST_ARM, ST_WRITE: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (w_take) begin
                        ena_q     <= 1'b1;
                        wea_q     <= 1'b1;
                        addra_q   <= w_lin;
                        dina_q    <= s_data;
                        eol_err_q <= (s_eol != w_col_wrap);
                        sof_err_q <= s_sof && (state_q == ST_WRITE);
                        col_q     <= col_d;
                        row_q     <= row_d;
                        lin_q     <= lin_d;
                        if (w_last) begin
                            frame_done_q <= 1'b1;
                            state_q      <= ST_IDLE;
                            busy_q       <= 1'b0;
                        end else begin
                            state_q <= ST_WRITE;
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ena        = ena_q;
    assign wea        = wea_q;
    assign addra      = addra_q;
    assign dina       = dina_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign sof_err    = sof_err_q;
    assign eol_err    = eol_err_q;

endmodule
`default_nettype wire

// File: tb/tb_bram_frame_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bram_frame_writer
//  Description : Self-checking bench for bram_frame_writer (4x3 frame).
//                A reference model turns every accepted beat into an expected
//                BRAM write, queued and compared when the write appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_frame_writer;

    localparam int IMG_W  = 4;
    localparam int IMG_H  = 3;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int NPIX   = IMG_W * IMG_H;

    logic              clka;
    logic              RESET_N;
    logic              start;
    logic              abort;
    logic              s_valid;
    logic              s_ready;
    logic              s_sof;
    logic              s_eol;
    logic [DATA_W-1:0] s_data;
    logic              ena;
    logic              wea;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina;
    logic              busy;
    logic              frame_done;
    logic              sof_err;
    logic              eol_err;

    bram_frame_writer #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_dut (
        .clka      (clka),
        .RESET_N   (RESET_N),
        .start     (start),
        .abort     (abort),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_sof     (s_sof),
        .s_eol     (s_eol),
        .s_data    (s_data),
        .ena       (ena),
        .wea       (wea),
        .addra     (addra),
        .dina      (dina),
        .busy      (busy),
        .frame_done(frame_done),
        .sof_err   (sof_err),
        .eol_err   (eol_err)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic              fd;
        logic              se;
        logic              ee;
    } exp_t;

    exp_t exp_q[$];

    int n_total = 0;
    int n_bad   = 0;
    int fd_seen = 0;

    // reference model state
    bit m_armed   = 1'b0;
    bit m_writing = 1'b0;
    int m_idx     = 0;
    int m_fd_exp  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, obs, expv, $time);
        end
    endtask

    // Write monitor: every write must match the head of the expectation queue;
    // pulses or enables without a write are never legal.
    always @(negedge clka) begin
        if (RESET_N) begin
            if (wea) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_write", 32'(addra), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("ena",        32'(ena),        32'd1);
                    chk("addra",      32'(addra),      32'(e.a));
                    chk("dina",       32'(dina),       32'(e.d));
                    chk("frame_done", 32'(frame_done), 32'(e.fd));
                    chk("sof_err",    32'(sof_err),    32'(e.se));
                    chk("eol_err",    32'(eol_err),    32'(e.ee));
                end
                if (frame_done) fd_seen++;
            end else if (ena || frame_done || sof_err || eol_err) begin
                chk("stray_pulse", {28'd0, ena, frame_done, sof_err, eol_err}, 32'd0);
            end
        end
    end

    task automatic model_accept(input bit sof, input bit eol, input logic [DATA_W-1:0] data);
        exp_t e;
        if (!m_writing && !sof) return;
        e.se = sof && m_writing;
        if (sof) m_idx = 0;
        e.a  = ADDR_W'(m_idx);
        e.d  = data;
        e.ee = (eol != ((m_idx % IMG_W) == IMG_W - 1));
        e.fd = (m_idx == NPIX - 1);
        exp_q.push_back(e);
        if (e.fd) begin
            m_armed   = 1'b0;
            m_writing = 1'b0;
            m_idx     = 0;
            m_fd_exp++;
        end else begin
            m_writing = 1'b1;
            m_idx++;
        end
    endtask

    // One-cycle beat; entered and left at posedge+1.
    task automatic beat(input bit sof, input bit eol, input logic [DATA_W-1:0] data);
        s_valid = 1'b1;
        s_sof   = sof;
        s_eol   = eol;
        s_data  = data;
        @(negedge clka);
        chk("s_ready", 32'(s_ready), 32'(m_armed));
        if (s_ready) model_accept(sof, eol, data);
        @(posedge clka); #1;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_eol   = 1'b0;
        chk("busy", 32'(busy), 32'(m_armed));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clka);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clka); #1;
        start = 1'b0;
        m_armed = 1'b1;
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        @(negedge clka);
        chk("ready_in_abort", 32'(s_ready), 32'd0);
        @(posedge clka); #1;
        abort     = 1'b0;
        m_armed   = 1'b0;
        m_writing = 1'b0;
        chk("busy_after_abort", 32'(busy), 32'd0);
    endtask

    // Drain pending writes and verify the frame bookkeeping.
    task automatic settle(input string tag);
        idle(3);
        chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_fd_count"}, 32'(fd_seen), 32'(m_fd_exp));
        chk({tag, "_busy"}, 32'(busy), 32'(m_armed));
    endtask

    initial begin
        RESET_N = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_eol   = 1'b0;
        s_data  = '0;
        idle(2);
        RESET_N = 1'b1;
        idle(1);

        // reset state
        chk("rst_ready", 32'(s_ready), 32'd0);
        chk("rst_busy",  32'(busy),    32'd0);
        chk("rst_addra", 32'(addra),   32'd0);
        chk("rst_dina",  32'(dina),    32'd0);
        chk("rst_ena",   32'(ena),     32'd0);

        // full frame, back-to-back
        pulse_start();
        for (int i = 0; i < NPIX; i++)
            beat(i == 0, (i % IMG_W) == IMG_W - 1, DATA_W'(8'h10 + i));
        settle("full");
        chk("full_ready_after", 32'(s_ready), 32'd0);

        // pre-SOF beats dropped, then frame with gaps
        pulse_start();
        for (int i = 0; i < 3; i++) beat(1'b0, 1'b0, DATA_W'(8'hE0 + i));
        for (int i = 0; i < NPIX; i++) begin
            beat(i == 0, (i % IMG_W) == IMG_W - 1, DATA_W'(8'h30 + i));
            idle(1);
        end
        settle("gaps");

        // mid-frame SOF resync
        pulse_start();
        for (int i = 0; i < 5; i++)
            beat(i == 0, (i % IMG_W) == IMG_W - 1, DATA_W'(8'h50 + i));
        beat(1'b1, 1'b0, 8'hAA);
        for (int i = 1; i < NPIX; i++)
            beat(1'b0, (i % IMG_W) == IMG_W - 1, DATA_W'(8'h60 + i));
        settle("resync");

        // EOL on pixel 2 instead of 3
        pulse_start();
        for (int i = 0; i < NPIX; i++)
            beat(i == 0, (i == 2) || (i == 7) || (i == 11), DATA_W'(8'h70 + i));
        settle("eol");

        // abort mid-frame; start pulses during frame ignored
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            if (i == 3) start = 1'b1;
            beat(i == 0, (i % IMG_W) == IMG_W - 1, DATA_W'(8'h80 + i));
            start = 1'b0;
        end
        pulse_abort();
        beat(1'b0, 1'b0, 8'h99);
        beat(1'b1, 1'b0, 8'h9A);
        settle("abort");

        // start and abort together in IDLE: stay idle
        start = 1'b1;
        abort = 1'b1;
        idle(1);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", 32'(busy), 32'd0);

        // re-arm, full frame
        pulse_start();
        for (int i = 0; i < NPIX; i++)
            beat(i == 0, (i % IMG_W) == IMG_W - 1, DATA_W'(8'hC0 + i));
        settle("rearm");

        // asynchronous reset mid-frame
        pulse_start();
        for (int i = 0; i < 5; i++)
            beat(i == 0, (i % IMG_W) == IMG_W - 1, DATA_W'(8'hD0 + i));
        s_valid = 1'b1;
        s_data  = 8'hDD;
        #2;
        RESET_N = 1'b0;
        #1;
        chk("arst_ena",   32'(ena),     32'd0);
        chk("arst_wea",   32'(wea),     32'd0);
        chk("arst_addra", 32'(addra),   32'd0);
        chk("arst_dina",  32'(dina),    32'd0);
        chk("arst_busy",  32'(busy),    32'd0);
        chk("arst_ready", 32'(s_ready), 32'd0);
        s_valid = 1'b0;
        exp_q.delete();
        m_armed   = 1'b0;
        m_writing = 1'b0;
        m_idx     = 0;
        idle(1);
        RESET_N = 1'b1;
        idle(1);
        chk("post_rst_ready", 32'(s_ready), 32'd0);
        chk("post_rst_busy",  32'(busy),    32'd0);
        beat(1'b1, 1'b0, 8'h11);
        settle("post_rst");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
